// File: rtl/pc_unit_if.sv
// Control and status bundle between decode/branch logic (master) and the
// program-counter unit (slave).
interface pc_unit_if #(
  parameter int W     = 32,
  parameter int OFF_W = 16,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             stall;
  logic             br_taken;
  logic [OFF_W-1:0] br_offset;
  logic             jmp;
  logic             call;
  logic [W-1:0]     jmp_target;
  logic             ret;
  logic             trap;
  logic             eret;

  logic [W-1:0]     pc;
  logic [W-1:0]     pc_plus;
  logic [W-1:0]     epc;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output stall, br_taken, br_offset, jmp, call, jmp_target, ret, trap, eret,
    input  pc, pc_plus, epc, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, br_taken, br_offset, jmp, call, jmp_target, ret, trap, eret,
    output pc, pc_plus, epc, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter with return-address stack and exception PC.
// Next PC priority: trap, eret, stall, ret, jmp/call, branch, sequential.
module pc_unit #(
  parameter int           W         = 32,
  parameter int           STEP      = 4,
  parameter logic [W-1:0] RESET_VEC = 32'hFFFF_FFFC,
  parameter logic [W-1:0] TRAP_VEC  = 32'h0000_0080,
  parameter int           OFF_W     = 16,
  parameter int           DEPTH     = 4
) (
  input logic     clk,
  input logic     rst,
  pc_unit_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     pc_q;
  logic [W-1:0]     epc_q;
  logic [W-1:0]     pc_inc;
  logic [W-1:0]     br_sext;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;
  logic [W-1:0]     ras [DEPTH];

  assign pc_inc  = pc_q + W'(STEP);
  assign br_sext = {{(W-OFF_W){bus.br_offset[OFF_W-1]}}, bus.br_offset};
  assign ptr_inc = ptr + PTR_W'(1);
  assign ptr_dec = ptr - PTR_W'(1);
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));

  // Push while full lands on ptr+1, which is the oldest entry of the ring.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      unf <= 1'b0;
      if (bus.trap) begin
        pc_q  <= TRAP_VEC;
        epc_q <= pc_q;
      end else if (bus.eret) begin
        pc_q <= epc_q;
      end else if (bus.stall) begin
        pc_q <= pc_q;
      end else if (bus.ret) begin
        if (bus.call) begin
          pc_q <= bus.jmp_target;
          if (!empty) begin
            ras[ptr] <= pc_inc;
          end else begin
            ras[ptr_inc] <= pc_inc;
            ptr          <= ptr_inc;
            count        <= count + CNT_W'(1);
          end
        end else if (!empty) begin
          pc_q  <= ras[ptr];
          ptr   <= ptr_dec;
          count <= count - CNT_W'(1);
        end else begin
          pc_q <= pc_inc;
          unf  <= 1'b1;
        end
      end else if (bus.jmp || bus.call) begin
        pc_q <= bus.jmp_target;
        if (bus.call) begin
          ras[ptr_inc] <= pc_inc;
          ptr          <= ptr_inc;
          if (full) ovf <= 1'b1;
          else      count <= count + CNT_W'(1);
        end
      end else if (bus.br_taken) begin
        pc_q <= pc_q + br_sext;
      end else begin
        pc_q <= pc_inc;
      end
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus   = pc_inc;
  assign bus.epc       = epc_q;
  assign bus.ras_count = count;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_ovf   = ovf;
  assign bus.ras_unf   = unf;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: stimulus queues hand-computed expectations,
// a monitor one step after each clock edge pops and compares them.
module tb_pc_unit;
  localparam logic [7:0] OP_NONE  = 8'h00;
  localparam logic [7:0] OP_RST   = 8'h80;
  localparam logic [7:0] OP_STALL = 8'h40;
  localparam logic [7:0] OP_BR    = 8'h20;
  localparam logic [7:0] OP_JMP   = 8'h10;
  localparam logic [7:0] OP_CALL  = 8'h08;
  localparam logic [7:0] OP_RET   = 8'h04;
  localparam logic [7:0] OP_TRAP  = 8'h02;
  localparam logic [7:0] OP_ERET  = 8'h01;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  string name_q[$];
  exp_t mon_e;
  string mon_nm;

  pc_unit_if #(.W(32), .OFF_W(16), .DEPTH(4)) bus ();

  pc_unit #(
    .W(32), .STEP(4), .RESET_VEC(32'hFFFF_FFFC), .TRAP_VEC(32'h0000_0080),
    .OFF_W(16), .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string nm, input string field,
                              input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", nm, field, act, req);
    end
  endtask

  // Monitor: every output sample after a stimulus edge is checked in order.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      vectors++;
      check_output(mon_nm, "pc",        bus.pc,                  mon_e.pc);
      check_output(mon_nm, "pc_plus",   bus.pc_plus,             mon_e.pc + 32'd4);
      check_output(mon_nm, "epc",       bus.epc,                 mon_e.epc);
      check_output(mon_nm, "ras_count", {29'd0, bus.ras_count},  {29'd0, mon_e.cnt});
      check_output(mon_nm, "ras_empty", {31'd0, bus.ras_empty},  {31'd0, mon_e.cnt == 3'd0});
      check_output(mon_nm, "ras_full",  {31'd0, bus.ras_full},   {31'd0, mon_e.cnt == 3'd4});
      check_output(mon_nm, "ras_ovf",   {31'd0, bus.ras_ovf},    {31'd0, mon_e.ovf});
      check_output(mon_nm, "ras_unf",   {31'd0, bus.ras_unf},    {31'd0, mon_e.unf});
    end
  end

  task automatic apply_stimulus(input string nm, input logic [7:0] ops,
                                input logic [15:0] off, input logic [31:0] tgt,
                                input logic [31:0] e_pc, input logic [31:0] e_epc,
                                input logic [2:0] e_cnt, input logic e_ovf,
                                input logic e_unf);
    exp_t e;
    @(negedge clk);
    rst            = ops[7];
    bus.stall      = ops[6];
    bus.br_taken   = ops[5];
    bus.jmp        = ops[4];
    bus.call       = ops[3];
    bus.ret        = ops[2];
    bus.trap       = ops[1];
    bus.eret       = ops[0];
    bus.br_offset  = off;
    bus.jmp_target = tgt;
    e.pc  = e_pc;
    e.epc = e_epc;
    e.cnt = e_cnt;
    e.ovf = e_ovf;
    e.unf = e_unf;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    rst = 1'b0;
    bus.stall = 0; bus.br_taken = 0; bus.jmp = 0; bus.call = 0;
    bus.ret = 0; bus.trap = 0; bus.eret = 0;
    bus.br_offset = '0; bus.jmp_target = '0;

    apply_stimulus("reset",     OP_RST,  16'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'd0, 0, 0);
    apply_stimulus("idle0",     OP_NONE, 16'h0, 32'h0, 32'h0000_0000, 32'h0, 3'd0, 0, 0);
    apply_stimulus("idle1",     OP_NONE, 16'h0, 32'h0, 32'h0000_0004, 32'h0, 3'd0, 0, 0);
    apply_stimulus("idle2",     OP_NONE, 16'h0, 32'h0, 32'h0000_0008, 32'h0, 3'd0, 0, 0);
    apply_stimulus("br_back",   OP_BR,   16'hFFF8, 32'h0, 32'h0, 32'h0, 3'd0, 0, 0);
    apply_stimulus("br_stall",  OP_BR | OP_STALL, 16'h0100, 32'h0, 32'h0, 32'h0, 3'd0, 0, 0);
    apply_stimulus("br_fwd",    OP_BR,   16'h0100, 32'h0, 32'h100, 32'h0, 3'd0, 0, 0);
    apply_stimulus("jmp_10",    OP_JMP,  16'h0, 32'h10, 32'h10, 32'h0, 3'd0, 0, 0);
    apply_stimulus("call1",     OP_CALL, 16'h0, 32'h100, 32'h100, 32'h0, 3'd1, 0, 0);
    apply_stimulus("call2",     OP_CALL, 16'h0, 32'h200, 32'h200, 32'h0, 3'd2, 0, 0);
    apply_stimulus("call3",     OP_CALL, 16'h0, 32'h300, 32'h300, 32'h0, 3'd3, 0, 0);
    apply_stimulus("call4",     OP_CALL, 16'h0, 32'h400, 32'h400, 32'h0, 3'd4, 0, 0);
    apply_stimulus("call5_ovf", OP_CALL, 16'h0, 32'h500, 32'h500, 32'h0, 3'd4, 1, 0);
    apply_stimulus("ret1",      OP_RET,  16'h0, 32'h0, 32'h404, 32'h0, 3'd3, 0, 0);
    apply_stimulus("ret2",      OP_RET,  16'h0, 32'h0, 32'h304, 32'h0, 3'd2, 0, 0);
    apply_stimulus("ret3",      OP_RET,  16'h0, 32'h0, 32'h204, 32'h0, 3'd1, 0, 0);
    apply_stimulus("ret4",      OP_RET,  16'h0, 32'h0, 32'h104, 32'h0, 3'd0, 0, 0);
    apply_stimulus("ret5_unf",  OP_RET,  16'h0, 32'h0, 32'h108, 32'h0, 3'd0, 0, 1);
    apply_stimulus("idle_unf0", OP_NONE, 16'h0, 32'h0, 32'h10C, 32'h0, 3'd0, 0, 0);
    apply_stimulus("jmp_100",   OP_JMP,  16'h0, 32'h100, 32'h100, 32'h0, 3'd0, 0, 0);
    apply_stimulus("call_200",  OP_CALL, 16'h0, 32'h200, 32'h200, 32'h0, 3'd1, 0, 0);
    apply_stimulus("callret",   OP_CALL | OP_RET, 16'h0, 32'h300, 32'h300, 32'h0, 3'd1, 0, 0);
    apply_stimulus("ret_top",   OP_RET,  16'h0, 32'h0, 32'h204, 32'h0, 3'd0, 0, 0);
    apply_stimulus("callret_e", OP_CALL | OP_RET, 16'h0, 32'h600, 32'h600, 32'h0, 3'd1, 0, 0);
    apply_stimulus("retjmp",    OP_RET | OP_JMP, 16'h0, 32'h900, 32'h208, 32'h0, 3'd0, 0, 0);
    apply_stimulus("jmp_br",    OP_JMP | OP_BR, 16'h0100, 32'h40, 32'h40, 32'h0, 3'd0, 0, 0);
    apply_stimulus("trap_stall",OP_TRAP | OP_STALL, 16'h0, 32'h0, 32'h80, 32'h40, 3'd0, 0, 0);
    apply_stimulus("idle_trap", OP_NONE, 16'h0, 32'h0, 32'h84, 32'h40, 3'd0, 0, 0);
    apply_stimulus("eret",      OP_ERET, 16'h0, 32'h0, 32'h40, 32'h40, 3'd0, 0, 0);
    apply_stimulus("jmp_top",   OP_JMP,  16'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h40, 3'd0, 0, 0);
    apply_stimulus("wrap_seq",  OP_NONE, 16'h0, 32'h0, 32'h0, 32'h40, 3'd0, 0, 0);
    apply_stimulus("wrap_br",   OP_BR,   16'hFFF0, 32'h0, 32'hFFFF_FFF0, 32'h40, 3'd0, 0, 0);
    apply_stimulus("call_700",  OP_CALL, 16'h0, 32'h700, 32'h700, 32'h40, 3'd1, 0, 0);
    apply_stimulus("rst_mixed", OP_RST | OP_CALL | OP_TRAP, 16'h0, 32'h900, 32'hFFFF_FFFC, 32'h0, 3'd0, 0, 0);
    apply_stimulus("post_rst",  OP_NONE, 16'h0, 32'h0, 32'h0, 32'h0, 3'd0, 0, 0);
    apply_stimulus("ret_empty", OP_RET,  16'h0, 32'h0, 32'h4, 32'h0, 3'd0, 0, 1);

    @(negedge clk);
    rst = 0; bus.stall = 0; bus.br_taken = 0; bus.jmp = 0; bus.call = 0;
    bus.ret = 0; bus.trap = 0; bus.eret = 0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the pRISC fetch stage; generational successor to the plain PC register.
- Holds the architectural PC and computes its next value from stall, branch, jump, call/return and trap controls.
- Adds an internal return-address stack (RAS) and an exception-PC (EPC) register.
- Drives the instruction-memory address; the decode/branch logic supplies the controls.

Parameters:
W, 32, PC width in bits
STEP, 4, sequential increment in bytes
RESET_VEC, 32'hFFFF_FFFC, PC value after reset; the first sequential fetch is therefore 0
TRAP_VEC, 32'h0000_0080, PC loaded on trap
OFF_W, 16, branch offset width; signed byte offset
DEPTH, 4, RAS entries (power of 2, at least 2)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
stall  in  1  hold PC and RAS
br_taken  in  1  take PC-relative branch
br_offset  in  OFF_W  signed byte offset, sign-extended to W
jmp  in  1  absolute jump
call  in  1  absolute jump that also pushes a return address
jmp_target  in  W  target for jmp and call
ret  in  1  pop RAS into PC
trap  in  1  exception entry
eret  in  1  exception return; PC <= EPC
pc  out  W  current PC (registered)
pc_plus  out  W  pc+STEP (combinational)
epc  out  W  saved exception PC (registered)
ras_count  out  log2(DEPTH)+1  valid RAS entries
ras_empty  out  1  ras_count==0
ras_full  out  1  ras_count==DEPTH
ras_ovf  out  1  one-cycle pulse: push while full
ras_unf  out  1  one-cycle pulse: ret while empty

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-high on rst. Reset overrides all other inputs.
- Reset values: pc=RESET_VEC, epc=0, ras_count=0, RAS pointer=0, ras_ovf=0, ras_unf=0. RAS entry contents are don't-care.
- Next-PC priority, highest first; the first matching row applies:
  1. trap: pc<=TRAP_VEC, epc<=pc (the current PC). RAS unchanged. Trap overrides stall.
  2. eret: pc<=epc. RAS unchanged.
  3. stall: pc, epc and RAS all hold. No pulses.
  4. ret (call may also be high, see below): if ras_count>0, pc<=top entry and the RAS pops. If empty, pc<=pc+STEP and ras_unf pulses.
  5. jmp or call: pc<=jmp_target. If call, push pc+STEP.
  6. br_taken: pc<=pc+sext(br_offset).
  7. otherwise: pc<=pc+STEP.
- Arithmetic: all adds are modulo 2^W, so wrap-around is silent. br_offset is sign-extended to W before the add.
- RAS organisation: circular buffer with a top pointer.
  - Push: write to ptr+1, advance ptr, count=min(count+1, DEPTH).
  - Push while full: overwrites the oldest entry, count stays DEPTH, ras_ovf pulses.
  - Pop: read ptr, retreat ptr, count-1.
- ret and call in the same cycle:
  - pc<=jmp_target.
  - Top entry is replaced in place by pc+STEP; count and ptr unchanged.
  - If the RAS was empty, behave as a plain call (push, count+1). ras_unf is not asserted.
- ret and jmp (no call) in the same cycle: ret wins; jmp is ignored.
- Latency: every change appears on pc one cycle after the sampling edge. pc_plus follows pc combinationally. pc changes only on a clock edge.
- Pulse outputs are registered. They are high for exactly the cycle after the event edge, and cleared by rst.
- Reset during any operation discards it: the next cycle shows reset values regardless of pending call, trap or stall.

Test Plan (W=32, STEP=4, DEPTH=4, TRAP_VEC=0x80):
- Reset then 3 idle cycles -> pc sequence FFFFFFFC, 0, 4, 8; epc=0; ras_empty=1.
- At pc=8, br_taken with br_offset=16'hFFF8 -> pc=0. Next cycle, br_offset=0x0100 with stall=1 -> pc stays 0. Release stall -> pc=0x100.
- Five calls from pc=0x10 to targets 0x100, 0x200, 0x300, 0x400, 0x500:
  - Fifth call pulses ras_ovf and count stays 4.
  - Four rets return 0x404, 0x304, 0x204, 0x104.
  - Fifth ret pulses ras_unf and pc advances by 4.
- call and ret together at pc=0x200, with top entry 0x104 and jmp_target 0x300 -> pc=0x300, top=0x204, count unchanged.
- trap at pc=0x40 with stall=1 -> pc=0x80, epc=0x40. Later eret -> pc=0x40.
- rst asserted in the same cycle as call and trap -> pc=FFFFFFFC, epc=0, ras_count=0, no pulses.
